// File: rtl/regfile_writeback_seq_pkg.sv
// rtl/regfile_writeback_seq_pkg.sv - shared encodings for the register-file write-back sequencer
package regfile_writeback_seq_pkg;

  // Write command kinds coming from execute decode
  typedef enum logic [2:0] {
    WK_NONE  = 3'd0,
    WK_CLRF  = 3'd1,
    WK_CLRW  = 3'd2,
    WK_MOVWF = 3'd3,
    WK_ALU   = 3'd4,
    WK_BIT   = 3'd5,
    WK_ALU_W = 3'd6
  } wr_kind_e;

  // Q-cycle phase encoding
  typedef enum logic [1:0] {
    QP_Q1 = 2'd0,
    QP_Q2 = 2'd1,
    QP_Q3 = 2'd2,
    QP_Q4 = 2'd3
  } q_phase_e;

  // Sequencer states
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } wb_state_e;

  // STATUS flag bit positions
  localparam int unsigned STATUS_C  = 0;
  localparam int unsigned STATUS_DC = 1;
  localparam int unsigned STATUS_Z  = 2;

  // Well-known direct file addresses
  localparam logic [4:0] INDF_FADDR   = 5'h00;
  localparam logic [4:0] STATUS_FADDR = 5'h03;
  localparam logic [4:0] FSR_FADDR    = 5'h04;

  // Width of the instruction f field / FSR offset
  localparam int unsigned DIRECT_BITS = 5;

endpackage

// File: rtl/regfile_addr_resolve.sv
// rtl/regfile_addr_resolve.sv - direct/indirect/bank file address formation
module regfile_addr_resolve
  import regfile_writeback_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned BANK_BITS  = 2,
  parameter int unsigned INDF_ADDR  = 0
) (
  input  logic [DIRECT_BITS-1:0] file_addr,
  input  logic [DATA_WIDTH-1:0]  fsr_in,
  output logic [ADDR_WIDTH-1:0]  res_addr,
  output logic [DIRECT_BITS-1:0] eff_addr,
  output logic                   null_ind
);

  localparam logic [DIRECT_BITS-1:0] INDF_F = DIRECT_BITS'(INDF_ADDR);

  logic indirect;
  logic fsr_unused;

  // FSR bits above the bank field never take part in addressing
  assign fsr_unused = ^fsr_in;

  // Pick the 5-bit offset: f field directly, or FSR low bits through INDF
  always_comb begin
    indirect = (file_addr == INDF_F);
    eff_addr = indirect ? fsr_in[DIRECT_BITS-1:0] : file_addr;
    null_ind = indirect && (fsr_in[DIRECT_BITS-1:0] == INDF_F);
  end

  generate
    if (BANK_BITS > 0) begin : g_bank
      logic [BANK_BITS-1:0] bank;

      // Upper half of each bank (f[4]=1) and all indirect accesses are banked by FSR
      always_comb begin
        if (indirect || file_addr[DIRECT_BITS-1]) begin
          bank = fsr_in[DIRECT_BITS +: BANK_BITS];
        end else begin
          bank = '0;
        end
      end

      assign res_addr = ADDR_WIDTH'({bank, eff_addr});
    end else begin : g_nobank
      assign res_addr = ADDR_WIDTH'(eff_addr);
    end
  endgenerate

endmodule

// File: rtl/regfile_writeback_seq.sv
// rtl/regfile_writeback_seq.sv - Q-phase write-back sequencer for GPR, W and STATUS
module regfile_writeback_seq
  import regfile_writeback_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 7,
  parameter int unsigned BANK_BITS   = 2,
  parameter int unsigned STATUS_ADDR = 3,
  parameter int unsigned INDF_ADDR   = 0,
  parameter int unsigned FLAG_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            q_phase,
  input  logic                  instr_valid,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [2:0]            wr_kind,
  input  logic                  dest_f,
  input  logic [FLAG_WIDTH-1:0] flag_mask,
  input  logic [4:0]            file_addr,
  input  logic [DATA_WIDTH-1:0] fsr_in,
  input  logic [DATA_WIDTH-1:0] status_in,
  input  logic [DATA_WIDTH-1:0] w_in,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [FLAG_WIDTH-1:0] alu_flags,
  output logic                  gpr_wr_en,
  output logic [ADDR_WIDTH-1:0] gpr_wr_addr,
  output logic [DATA_WIDTH-1:0] gpr_wr_data,
  output logic                  w_wr_en,
  output logic [DATA_WIDTH-1:0] w_wr_data,
  output logic                  status_wr_en,
  output logic [DATA_WIDTH-1:0] status_wr_data,
  output logic                  busy
);

  localparam logic [4:0]            STATUS_F = 5'(STATUS_ADDR);
  localparam logic [FLAG_WIDTH-1:0] Z_MASK   = FLAG_WIDTH'(1 << STATUS_Z);

  wb_state_e state_q, state_d;

  // Fields captured at Q2 for the pending write
  wr_kind_e              kind_q;
  logic                  dest_f_q;
  logic [FLAG_WIDTH-1:0] flag_mask_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  null_q;
  logic                  status_dest_q;

  // Address resolution of the live instruction
  logic [ADDR_WIDTH-1:0] res_addr;
  logic [4:0]            eff_addr;
  logic                  null_ind;

  // Control decode
  logic arm_req;
  logic arm_fire;
  logic commit_fire;

  // Commit payload
  logic                  gpr_tgt;
  logic                  w_tgt;
  logic [DATA_WIDTH-1:0] gpr_data;
  logic [DATA_WIDTH-1:0] w_data;
  logic [FLAG_WIDTH-1:0] mask_eff;
  logic [FLAG_WIDTH-1:0] flag_val;
  logic [DATA_WIDTH-1:0] status_base;
  logic [FLAG_WIDTH-1:0] merged_flags;
  logic                  gpr_we;
  logic                  status_we;
  logic [DATA_WIDTH-1:0] status_data;

  regfile_addr_resolve #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BANK_BITS  (BANK_BITS),
    .INDF_ADDR  (INDF_ADDR)
  ) u_addr_resolve (
    .file_addr (file_addr),
    .fsr_in    (fsr_in),
    .res_addr  (res_addr),
    .eff_addr  (eff_addr),
    .null_ind  (null_ind)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: arm at an unstalled Q2, leave on flush or on an unstalled Q4
  always_comb begin
    arm_req = (q_phase == QP_Q2) && instr_valid && !stall && !flush &&
              (wr_kind != WK_NONE);
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (arm_req) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if ((q_phase == QP_Q4) && !stall) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: busy flag and arm/commit events (flush beats commit)
  always_comb begin
    busy        = (state_q == ST_ARMED);
    arm_fire    = (state_q == ST_IDLE) && arm_req;
    commit_fire = (state_q == ST_ARMED) && (q_phase == QP_Q4) && !stall && !flush;
  end

  // Capture kind, d-bit, flag mask and resolved address when arming
  always_ff @(posedge clk) begin
    if (rst) begin
      kind_q        <= WK_NONE;
      dest_f_q      <= 1'b0;
      flag_mask_q   <= '0;
      addr_q        <= '0;
      null_q        <= 1'b0;
      status_dest_q <= 1'b0;
    end else if (arm_fire) begin
      kind_q        <= wr_kind_e'(wr_kind);
      dest_f_q      <= dest_f;
      flag_mask_q   <= flag_mask;
      addr_q        <= res_addr;
      null_q        <= null_ind;
      status_dest_q <= (eff_addr == STATUS_F);
    end
  end

  // Decode the pending write into targets, data and flag updates
  always_comb begin
    gpr_tgt  = 1'b0;
    w_tgt    = 1'b0;
    gpr_data = '0;
    w_data   = '0;
    mask_eff = '0;
    flag_val = '0;
    case (kind_q)
      WK_CLRF: begin
        gpr_tgt  = 1'b1;
        mask_eff = Z_MASK;
        flag_val = Z_MASK;
      end
      WK_CLRW: begin
        w_tgt    = 1'b1;
        mask_eff = Z_MASK;
        flag_val = Z_MASK;
      end
      WK_MOVWF: begin
        gpr_tgt  = 1'b1;
        gpr_data = w_in;
      end
      WK_ALU: begin
        if (dest_f_q) begin
          gpr_tgt  = 1'b1;
          gpr_data = alu_result;
        end else begin
          w_tgt  = 1'b1;
          w_data = alu_result;
        end
        mask_eff = flag_mask_q;
        flag_val = alu_flags;
      end
      WK_BIT: begin
        gpr_tgt  = 1'b1;
        gpr_data = alu_result;
      end
      WK_ALU_W: begin
        w_tgt    = 1'b1;
        w_data   = alu_result;
        mask_eff = flag_mask_q;
        flag_val = alu_flags;
      end
      default: ;
    endcase
  end

  // Merge flags into STATUS; a file write to STATUS becomes a STATUS write
  always_comb begin
    status_base  = (gpr_tgt && status_dest_q) ? gpr_data : status_in;
    merged_flags = (flag_val & mask_eff) | (status_base[FLAG_WIDTH-1:0] & ~mask_eff);
    status_data  = {status_base[DATA_WIDTH-1:FLAG_WIDTH], merged_flags};
    gpr_we       = gpr_tgt && !null_q && !status_dest_q;
    status_we    = (gpr_tgt && status_dest_q && !null_q) || (|mask_eff);
  end

  // Registered one-cycle strobes; data/address hold their last committed value
  always_ff @(posedge clk) begin
    if (rst) begin
      gpr_wr_en      <= 1'b0;
      gpr_wr_addr    <= '0;
      gpr_wr_data    <= '0;
      w_wr_en        <= 1'b0;
      w_wr_data      <= '0;
      status_wr_en   <= 1'b0;
      status_wr_data <= '0;
    end else begin
      gpr_wr_en    <= commit_fire && gpr_we;
      w_wr_en      <= commit_fire && w_tgt;
      status_wr_en <= commit_fire && status_we;
      if (commit_fire) begin
        gpr_wr_addr    <= addr_q;
        gpr_wr_data    <= gpr_data;
        w_wr_data      <= w_data;
        status_wr_data <= status_data;
      end
    end
  end

endmodule

// File: doc/regfile_writeback_seq.md
Name: regfile_writeback_seq

Overview:
Parametrised write-back sequencer for the PIC16C5x-family core. It replaces the purely combinational write-command decode with a Q-phase-driven state machine. The block latches a resolved file address in Q2 (direct or FSR-indirect, with bank bits) and commits exactly one write in Q4 to the GPR, W or STATUS. It also supports stall/flush and merges STATUS-as-destination writes. It sits between the execute decode/ALU and the register file / W register.

Parameters:
DATA_WIDTH, 8, GPR/W/STATUS data width
ADDR_WIDTH, 7, resolved register-file address width (5 direct bits + bank bits)
BANK_BITS, 2, FSR bits used as bank select; 0 disables banking
STATUS_ADDR, 3, direct file address of STATUS
INDF_ADDR, 0, direct file address of INDF (indirect access)
FLAG_WIDTH, 3, ALU flag count {Z, DC, C}, mapped to STATUS[FLAG_WIDTH-1:0]

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
q_phase  in  2  current Q-cycle: 0=Q1, 1=Q2, 2=Q3, 3=Q4
instr_valid  in  1  instruction in execute is live
stall  in  1  hold current phase action
flush  in  1  cancel pending write (skip/branch)
wr_kind  in  3  0 NONE, 1 CLRF, 2 CLRW, 3 MOVWF, 4 ALU (d-selected), 5 BIT (always to f), 6 ALU_W (literal op, to W)
dest_f  in  1  d-bit: 1 to file, 0 to W (kinds 4 only)
flag_mask  in  FLAG_WIDTH  flags the instruction updates
file_addr  in  5  instruction f field
fsr_in  in  DATA_WIDTH  FSR contents
status_in  in  DATA_WIDTH  current STATUS
w_in  in  DATA_WIDTH  current W
alu_result  in  DATA_WIDTH  ALU result, valid at Q4
alu_flags  in  FLAG_WIDTH  ALU flags, valid at Q4
gpr_wr_en  out  1  one-cycle GPR write strobe
gpr_wr_addr  out  ADDR_WIDTH  resolved write address
gpr_wr_data  out  DATA_WIDTH  GPR write data
w_wr_en  out  1  one-cycle W write strobe
w_wr_data  out  DATA_WIDTH  W write data
status_wr_en  out  1  one-cycle STATUS write strobe
status_wr_data  out  DATA_WIDTH  STATUS write data
busy  out  1  write armed, not yet committed

Behaviour:
- States: IDLE, ARMED.
- Reset: state IDLE; all strobes 0; all addr/data outputs 0; busy 0. Reset takes effect in any state, and an armed write is discarded.
- IDLE→ARMED: on the clock edge with q_phase=Q2, instr_valid=1, stall=0, flush=0 and wr_kind≠NONE.
  - Latch kind, dest_f, flag_mask and the resolved address.
  - Address resolution: if file_addr=INDF_ADDR, use eff=fsr_in[4:0] and bank=fsr_in[5+:BANK_BITS]. Otherwise use eff=file_addr; bank is the FSR bank bits if file_addr[4]=1, else 0.
  - gpr_wr_addr = {bank, eff}.
- Null indirect: indirect access whose eff=INDF_ADDR is a null write. Suppress the GPR write; STATUS flags still update.
- ARMED→IDLE with commit: on the edge with q_phase=Q4 and stall=0. Strobes are registered and high for exactly the following cycle. Latency from the Q4 edge is 1 clock.
- Commit data by kind:
  - CLRF: GPR←0; Z←1.
  - CLRW: W←0; Z←1.
  - MOVWF: GPR←w_in; no flags.
  - ALU: GPR or W←alu_result per dest_f; masked flags.
  - BIT: GPR←alu_result; no flags.
  - ALU_W: W←alu_result; masked flags.
- Flag merge: status_wr_data = {status_in[DATA_WIDTH-1:FLAG_WIDTH], f}, where f[i] = alu_flags[i] if flag_mask[i], else status_in[i]. status_wr_en=1 only if any flag is affected.
- STATUS as destination: when the resolved GPR address equals STATUS_ADDR (bank-independent), gpr_wr_en is suppressed. status_wr_en=1 and status_wr_data = {gpr data upper bits, merged flags}; affected flags take the ALU value, unaffected flags take the gpr data bits.
- Stall while ARMED: hold state and latched fields; no strobe. Commit on the first Q4 edge with stall=0.
- Flush while ARMED, at any phase: return to IDLE, no strobe. Flush wins over a simultaneous Q4 commit.
- Q2 with instr_valid while ARMED is a protocol error: ignore the new request and keep the pending write.
- busy = (state==ARMED).

Decomposition:
- Shared package/define file: wr_kind encodings, Q-phase encodings, STATUS bit indices (Z=2, DC=1, C=0), INDF/STATUS/FSR addresses.
- One sub-module: regfile_addr_resolve (combinational direct/indirect/bank address formation plus null-indirect flag), reused by the read path.

Test Plan:
- ADDWF f=0x12, d=1, FSR=0x40, alu_result=0x5A, flags Z=0 C=1, mask=111 → Q4+1: gpr_wr_en=1, addr=0x52, data=0x5A; status low bits=001.
- INDF write, FSR=0x27, MOVWF, W=0xA5 → addr=0x27, data=0xA5; status_wr_en=0.
- INDF write with FSR=0x00 → no strobes at all.
- CLRF f=STATUS, status_in=0x1F → gpr_wr_en=0; status_wr_en=1; data=0x04.
- ALU op armed, stall high across two Q4 windows → no strobe until the first unstalled Q4; single pulse, correct data.
- Flush asserted in Q3 of an armed write, then rst asserted mid-ARMED on another instruction → no strobes; busy=0 next cycle.
